// File: rtl/alu_share_arbiter.sv
// Shares one multi-cycle ALU between two 4-phase requesters, using round-robin arbitration.
// Define ALU_ARB_FIXED_PRIO_EN to switch to fixed priority, where requester 0 wins every tie.
module alu_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1   // legal range 1..15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [3:0]       op0_i,
  input  logic [3:0]       op1_i,
  output logic             sel_o,
  output logic [3:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done0_o,
  output logic             done1_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OP_W  = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               sel_q, sel_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               busy_q, busy_d;

  logic               any_req_c;
  logic               grant_c;
  logic               owner_req_c;

  assign any_req_c   = req0_i | req1_i;
  assign owner_req_c = sel_q ? req1_i : req0_i;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant_c = ~req0_i;
`else
  // Last points at the most recent grantee; on a tie the other requester wins.
  logic last_q, last_d;

  assign grant_c = (req0_i && req1_i) ? ~last_q : req1_i;
  assign last_d  = (state_q == IDLE && any_req_c) ? grant_c : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done0_d  = done0_q;
    done1_d  = done1_q;
    unique case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d = EXEC;
          sel_d   = grant_c;
          op_d    = grant_c ? op1_i : op0_i;
          cnt_d   = CNT_INIT;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d = alu_result_i;
          state_d  = DONE;
          done0_d  = ~sel_q;
          done1_d  = sel_q;
        end
      end
      DONE: begin
        if (!owner_req_c) begin
          state_d = IDLE;
          done0_d = 1'b0;
          done1_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done0_d = 1'b0;
        done1_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign sel_o    = sel_q;
  assign alu_op_o = op_q;
  assign result_o = result_q;
  assign done0_o  = done0_q;
  assign done1_o  = done1_q;
  assign busy_o   = busy_q;

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter WIDTH, 32, data width of ALU result and Result.
REQ-002 Parameter ALU_LAT, 1, ALU cycles from stable Sel/AluOp to valid AluResult; legal range 1..15.
REQ-003 Port Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port Rst_n  in  1  reset; asynchronous, active-low.
REQ-005 Port Req0 / Req1  in  1 each  requester 0 / 1 operation request, level, 4-phase handshake with Done0 / Done1.
REQ-006 Port Op0 / Op1  in  4 each  ALU operation code of requester 0 / 1.
REQ-007 Port Sel  out  1  select for the shared 2-to-1 operand muxes; 0 = requester 0 operands, 1 = requester 1.
REQ-008 Port AluOp  out  4  operation code driven to the shared ALU.
REQ-009 Port AluResult  in  WIDTH  shared ALU output.
REQ-010 Port Result  out  WIDTH  registered result of the last completed operation.
REQ-011 Port Done0 / Done1  out  1 each  completion acknowledge to requester 0 / 1.
REQ-012 Port Busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, DONE; encoding is implementation choice.
REQ-014 IDLE, no Req high: stay IDLE; all outputs hold.
REQ-015 IDLE, one Req high at edge: grant that requester; Sel <= its index, AluOp <= its Op, counter <= ALU_LAT-1, go EXEC.
REQ-016 IDLE, both Req high: grant per arbitration policy (REQ-025/026).
REQ-017 Sel and AluOp SHALL remain constant from grant edge until the next grant; later Op/Req changes ignored.
REQ-018 EXEC: counter nonzero -> decrement; counter zero -> Result <= AluResult, go DONE; capture occurs ALU_LAT edges after grant edge.
REQ-019 DONE: Done of granted requester SHALL be high (registered), other Done low; stay while that Req high; when it is low at edge, Done <= 0, go IDLE.
REQ-020 Requester re-raising Req after its Done falls is a new request; earliest re-grant is the edge after Done falls.
REQ-021 Req of granted requester dropping during EXEC (protocol violation): operation still completes; Done high exactly one cycle.
REQ-022 Requests arriving while Busy SHALL be held pending (level) and arbitrated in next IDLE cycle; none lost.
REQ-023 Done0 and Done1 SHALL never be high simultaneously.
REQ-024 Throughput: with ALU_LAT=L, back-to-back requests from alternating requesters complete every L+2 cycles minimum.

Configuration
REQ-025 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin; 1-bit Last pointer updated on every grant; on tie, requester != Last wins.
REQ-026 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties; Last pointer not implemented; all other behaviour identical.

Reset
REQ-027 Rst_n low SHALL immediately force IDLE, Sel=0, AluOp=0, Result=0, Done0=Done1=0, Busy=0, counter=0, Last=1 (requester 0 wins first tie).
REQ-028 Reset during EXEC or DONE abandons operation; no Done issued after release; pending Req re-arbitrated from IDLE.
REQ-029 Outputs SHALL not change on Rst_n release edge; first grant no earlier than first rising Clk edge with Rst_n high.

Verification
REQ-030 ALU_LAT=1, Req0 high with Op0=4'h2, AluResult=32'h0000_0005 -> Sel=0, AluOp=2 after edge 0; Result=5, Done0 high after edge 1; Done0 falls edge after Req0 drops.
REQ-031 Round-robin, Req0 and Req1 high together, held, each dropped on its Done -> grants 0, 1, 0, 1; Done0/Done1 never overlap.
REQ-032 ALU_LAT=3, Req1 Op1=4'h7, Op1 changed to 4'h1 during EXEC -> AluOp stays 7 for 3 cycles; Result captured at grant edge +3.
REQ-033 Rst_n asserted mid-EXEC with Req0 high -> all outputs zero immediately; after release Req0 re-granted, Done0 after ALU_LAT+1 edges.
REQ-034 ALU_ARB_FIXED_PRIO_EN defined, Req0 and Req1 continuously re-requesting -> requester 0 granted every time, Done1 never asserts.
